// File: rtl/seven_segment_scan.sv
// ---------------------------------------------------------------------------
// seven_segment_scan
//   Time-multiplexed scan driver for a DIGITS-wide hex display. Presents one
//   nibble at a time to a downstream seven-segment decoder together with a
//   one-hot digit enable. Each digit slot is SCAN_DIV cycles long and starts
//   with BLANK_CYCLES of all-off selects to suppress ghosting. New values are
//   applied only at the frame boundary (wrap from the last digit to digit 0),
//   so a frame never mixes old and new digits.
//
//   Optional: define SEVEN_SEGMENT_SCAN_LZB_EN for leading-zero blanking.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_load         single-cycle request to display i_value
//   i_value        new value, digit k = i_value[4k+3:4k]
//   o_digit_data   nibble for the decoder (0 while blanked)
//   o_digit_sel    one-hot active-high digit enable, all zero while blanked
//   o_blank        current slot shows nothing
//   o_pending      a loaded value waits for the next frame boundary
//   o_updated      one-cycle pulse after a new value took effect
// ---------------------------------------------------------------------------
module seven_segment_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DIGITS*4-1:0]   i_value,
  output logic [3:0]            o_digit_data,
  output logic [DIGITS-1:0]     o_digit_sel,
  output logic                  o_blank,
  output logic                  o_pending,
  output logic                  o_updated
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [DIGITS*4-1:0]    r_disp;
  logic [DIGITS*4-1:0]    r_stage;

  logic [DIGITS-1:0][3:0] w_nibs;
  logic [DIGITS-1:0]      w_onehot;
  logic                   w_slot_end;
  logic                   w_wrap;
  logic                   w_suppress;

  assign w_nibs     = r_disp;
  assign w_onehot   = DIGITS'(1) << r_idx;
  assign w_slot_end = (r_cnt == LAST_CNT);
  // Frame boundary: last cycle of the last digit's slot.
  assign w_wrap     = w_slot_end && (r_idx == LAST_IDX);

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
  // w_lz[k]: digit k and every digit above it are zero. Each bit is computed
  // directly from the display register so there is no chained logic; digit 0
  // is never suppressed so a zero value still shows a single "0".
  logic [DIGITS-1:0] w_lz;
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    if (k == 0) begin : g_d0
      assign w_lz[k] = 1'b0;
    end else begin : g_dk
      assign w_lz[k] = ~|r_disp[DIGITS*4-1:4*k];
    end
  end
  assign w_suppress = w_lz[r_idx];
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_stage      <= '0;
      o_digit_data <= 4'd0;
      o_digit_sel  <= '0;
      o_blank      <= 1'b1;
      o_pending    <= 1'b0;
      o_updated    <= 1'b0;
    end else begin
      // Outputs are registered from the current state, giving one cycle of
      // latency relative to the counter/state transition.
      if (r_state == ST_SHOW && !w_suppress) begin
        o_digit_sel  <= w_onehot;
        o_digit_data <= w_nibs[r_idx];
        o_blank      <= 1'b0;
      end else begin
        o_digit_sel  <= '0;
        o_digit_data <= 4'd0;
        o_blank      <= 1'b1;
      end

      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;

      case (r_state)
        ST_BLANK: if (r_cnt == LAST_BLK) r_state <= ST_SHOW;
        ST_SHOW: begin
          if (w_slot_end) begin
            r_state <= ST_BLANK;
            r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
          end
        end
        default: r_state <= ST_BLANK;
      endcase

      // A load on the wrap cycle goes straight to the display register;
      // otherwise it is staged, newest value wins.
      o_updated <= 1'b0;
      if (w_wrap) begin
        if (i_load)         r_disp <= i_value;
        else if (o_pending) r_disp <= r_stage;
        o_updated <= i_load | o_pending;
        o_pending <= 1'b0;
      end else if (i_load) begin
        r_stage   <= i_value;
        o_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Time-multiplexed scan driver that sits directly upstream of the seven-segment decoder.
- Holds a DIGITS-wide hex value and presents one nibble at a time on digit_data, which feeds the decoder's 4-bit data input.
- Drives the matching one-hot digit select for the common-anode/cathode enables.
- Applies new values only at frame boundaries, so a display never shows a mix of old and new digits.

Parameters:
- DIGITS, 4, number of digits scanned; must be 2 to 8.
- SCAN_DIV, 1000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 8, cycles at the start of each slot with all selects off (ghosting guard); must be 1 or more.
- CNT_W, 16, prescale counter width; SCAN_DIV must be no more than 2^CNT_W.

Ports:
- clk, input, 1: single system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- load, input, 1: single-cycle request to display value.
- value, input, DIGITS*4: new value; digit 0 = value[3:0] (rightmost), digit k = value[4k+3:4k].
- digit_data, output, 4: nibble for the decoder.
- digit_sel, output, DIGITS: one-hot active-high digit enable; all zero while blanked.
- blank, output, 1: high when the current slot shows nothing; downstream gates segments with it.
- pending, output, 1: a loaded value is waiting for the next frame boundary.
- updated, output, 1: one-cycle pulse when a new value becomes visible.

Behaviour:
- All outputs are registered. Reset values: digit_data=0, digit_sel=0, blank=1, pending=0, updated=0.
- Internal reset values: prescale counter=0, digit index=0, state=BLANK, display register=0, staging register=0.
- FSM states: BLANK and SHOW.
  - BLANK: digit_sel=0, blank=1. Counter counts 0..BLANK_CYCLES-1. On count BLANK_CYCLES-1, go to SHOW.
  - SHOW: digit_sel=1<<index, digit_data=display nibble[index], blank=0. Counter continues to SCAN_DIV-1.
  - At end of slot: counter goes to 0, state goes to BLANK, index goes to index+1.
  - Index wraps from DIGITS-1 to 0. This wrap is the frame boundary.
- Output timing: outputs reflect the state/index one cycle after the counter transition, i.e. one register stage of latency.
- Load handling:
  - load with no frame boundary in that cycle: staging <= value, pending <= 1. A later load overwrites staging; only the newest value is shown.
  - At a frame boundary with load=1: display <= value directly (bypasses staging), pending <= 0, updated pulses next cycle.
  - At a frame boundary with load=0 and pending=1: display <= staging, pending <= 0, updated pulses next cycle.
  - At a frame boundary with load=0 and pending=0: display unchanged, no pulse.
- The display register changes only on the wrap cycle, while the FSM enters BLANK. A new frame therefore always starts on digit 0 with the new value.
- Reset mid-frame: all state returns to reset values on the next edge. The staging value and any pending request are discarded.
- The counter never exceeds SCAN_DIV-1. Wrap arithmetic is modulo DIGITS on the index, with no out-of-range select.

Optional Feature:
- Macro: SEVEN_SEGMENT_SCAN_LZB_EN (leading-zero blanking).
- With the macro defined:
  - In SHOW, a digit k is treated as blanked when it and every digit above it hold 0. Blanked means blank=1 and digit_sel=0 for the whole slot; the timing is unchanged.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Suppression is computed from the display register, not from staging.
- Without the macro: every digit is shown in SHOW, including leading zeros. No suppression logic is synthesised.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=16, BLANK_CYCLES=2.
- Reset then free-run:
  - blank=1 and digit_sel=0 for 2 cycles; then digit_sel=0001, digit_data=0 for 14 cycles.
  - Then 2 blank cycles and digit_sel=0010. The 4 slots repeat every 64 cycles.
- load value=16'h3A7F mid-frame:
  - pending=1 until the wrap, and the old digits stay visible.
  - updated pulses once after the wrap.
  - Next frame shows F, 7, A, 3 on digit_sel 0001, 0010, 0100, 1000.
- Two loads (16'h1111, then 16'h2222) within one frame: only 2222 is displayed, and exactly one updated pulse occurs.
- load 16'h5555 asserted exactly on the wrap cycle: the new frame shows 5 on digit 0 immediately, with pending=0 throughout.
- rst asserted during the SHOW of digit 2 with pending=1:
  - Next cycle: digit_sel=0, blank=1, pending=0.
  - After release, the scan restarts at digit 0 with display=0.
- With SEVEN_SEGMENT_SCAN_LZB_EN, load 16'h0040:
  - Digits 3 and 2 are blanked (digit_sel=0, blank=1 in their SHOW windows).
  - Digit 1 shows 4 and digit 0 shows 0.
  - With value 16'h0000, only digit 0 shows 0.
